// File: rtl/minrv32_mem_arbiter.sv
// Two-master arbiter for the minrv32 native memory bus: round-robin grant with
// transaction locking, a bus-hang watchdog and sticky protocol-violation flags.
module minrv32_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        m0_mem_valid,
  input  logic        m0_mem_instr,
  input  logic [31:0] m0_mem_addr,
  input  logic [31:0] m0_mem_wdata,
  input  logic [3:0]  m0_mem_wstrb,
  output logic        m0_mem_ready,
  output logic [31:0] m0_mem_rdata,
  input  logic        m1_mem_valid,
  input  logic        m1_mem_instr,
  input  logic [31:0] m1_mem_addr,
  input  logic [31:0] m1_mem_wdata,
  input  logic [3:0]  m1_mem_wstrb,
  output logic        m1_mem_ready,
  output logic [31:0] m1_mem_rdata,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  grant,
  output logic        timeout_err,
  output logic        proto_err
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);
  localparam logic WD_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic            last_owner, last_owner_nxt;
  logic [CW-1:0]   wait_cnt, wait_cnt_nxt;
  logic            set_timeout, set_proto;
  logic            owned, own1, own_valid, oth_valid, wd_fire, done;
  logic [31:0]     own_rdata;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last_owner  <= 1'b1;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      state       <= state_nxt;
      last_owner  <= last_owner_nxt;
      wait_cnt    <= wait_cnt_nxt;
      timeout_err <= timeout_err | set_timeout;
      proto_err   <= proto_err | set_proto;
    end
  end

  assign grant = {state == OWN1, state == OWN0};

  always_comb begin
    state_nxt      = state;
    last_owner_nxt = last_owner;
    wait_cnt_nxt   = wait_cnt;
    set_timeout    = 1'b0;
    set_proto      = 1'b0;
    owned          = (state == OWN0) || (state == OWN1);
    own1           = (state == OWN1);
    own_valid      = own1 ? m1_mem_valid : m0_mem_valid;
    oth_valid      = own1 ? m0_mem_valid : m1_mem_valid;
    wd_fire        = 1'b0;
    done           = 1'b0;
    own_rdata      = 32'd0;
    mem_valid      = 1'b0;
    mem_instr      = 1'b0;
    mem_addr       = 32'd0;
    mem_wdata      = 32'd0;
    mem_wstrb      = 4'd0;

    case (state)
      IDLE: begin
        // last_owner resets to 1 so master 0 wins the first tie
        if (m0_mem_valid && m1_mem_valid) state_nxt = last_owner ? OWN0 : OWN1;
        else if (m0_mem_valid)            state_nxt = OWN0;
        else if (m1_mem_valid)            state_nxt = OWN1;
      end
      OWN0, OWN1: begin
        mem_instr = own1 ? m1_mem_instr : m0_mem_instr;
        mem_addr  = own1 ? m1_mem_addr  : m0_mem_addr;
        mem_wdata = own1 ? m1_mem_wdata : m0_mem_wdata;
        mem_wstrb = own1 ? m1_mem_wstrb : m0_mem_wstrb;
        own_rdata = mem_rdata;
        // A genuine mem_ready in the timeout cycle takes precedence
        wd_fire   = WD_EN && own_valid && (wait_cnt == TMAX) && !mem_ready;
        if (!own_valid) begin
          set_proto = 1'b1;
          state_nxt = IDLE;
        end else begin
          mem_valid = !wd_fire;
          if (mem_ready || wd_fire) begin
            done           = 1'b1;
            set_timeout    = wd_fire;
            last_owner_nxt = own1;
            if (wd_fire) own_rdata = ERR_RDATA;
            if (oth_valid) state_nxt = own1 ? OWN0 : OWN1;
            else           state_nxt = IDLE;
          end else if (wait_cnt != TMAX) begin
            wait_cnt_nxt = wait_cnt + CW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (state_nxt != IDLE && state_nxt != state) wait_cnt_nxt = '0;
  end

  assign m0_mem_ready = (state == OWN0) && done;
  assign m1_mem_ready = (state == OWN1) && done;
  assign m0_mem_rdata = (state == OWN0) ? own_rdata : 32'd0;
  assign m1_mem_rdata = (state == OWN1) ? own_rdata : 32'd0;

  wire unused_ok = owned;

endmodule

// File: tb/tb_minrv32_mem_arbiter.sv
// Directed bench for minrv32_mem_arbiter: vector table plus hand-written
// sequences for watchdog, ready/timeout tie, protocol error and async reset.
module tb_minrv32_mem_arbiter;

  localparam logic [31:0] A0 = 32'h0001_0000;
  localparam logic [31:0] A1 = 32'h0002_0000;
  localparam logic [31:0] WD1 = 32'hCAFE_F00D;

  logic        clock = 1'b0;
  logic        reset;
  logic        m0_mem_valid, m0_mem_instr, m1_mem_valid, m1_mem_instr;
  logic [31:0] m0_mem_addr, m0_mem_wdata, m1_mem_addr, m1_mem_wdata;
  logic [3:0]  m0_mem_wstrb, m1_mem_wstrb;
  logic        m0_mem_ready, m1_mem_ready;
  logic [31:0] m0_mem_rdata, m1_mem_rdata;
  logic        mem_valid, mem_instr, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic [1:0]  grant;
  logic        timeout_err, proto_err;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  minrv32_mem_arbiter #(.TIMEOUT_CYCLES(4), .ERR_RDATA(32'hDEAD_BEEF)) dut (
    .clock(clock), .reset(reset),
    .m0_mem_valid(m0_mem_valid), .m0_mem_instr(m0_mem_instr), .m0_mem_addr(m0_mem_addr),
    .m0_mem_wdata(m0_mem_wdata), .m0_mem_wstrb(m0_mem_wstrb), .m0_mem_ready(m0_mem_ready),
    .m0_mem_rdata(m0_mem_rdata),
    .m1_mem_valid(m1_mem_valid), .m1_mem_instr(m1_mem_instr), .m1_mem_addr(m1_mem_addr),
    .m1_mem_wdata(m1_mem_wdata), .m1_mem_wstrb(m1_mem_wstrb), .m1_mem_ready(m1_mem_ready),
    .m1_mem_rdata(m1_mem_rdata),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .grant(grant), .timeout_err(timeout_err), .proto_err(proto_err)
  );

  typedef struct packed {
    logic        rst;
    logic        m0v;
    logic        m1v;
    logic        rdy;
    logic [31:0] rd;
    logic [1:0]  g;
    logic        mv;
    logic [31:0] ma;
    logic        r0;
    logic [31:0] d0;
    logic        r1;
    logic [31:0] d1;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(logic rst, logic m0v, logic m1v, logic rdy, logic [31:0] rd,
                              logic [1:0] g, logic mv, logic [31:0] ma,
                              logic r0, logic [31:0] d0, logic r1, logic [31:0] d1);
    vec_t v;
    v = {rst, m0v, m1v, rdy, rd, g, mv, ma, r0, d0, r1, d1};
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drv(input logic m0v, input logic m1v, input logic rdy, input logic [31:0] rd);
    m0_mem_valid = m0v;
    m1_mem_valid = m1v;
    mem_ready    = rdy;
    mem_rdata    = rd;
  endtask

  task automatic cyc_end();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drv(1'b0, 1'b0, 1'b0, 32'd0);
    cyc_end();
    reset = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    m0_mem_instr = 1'b1;
    m0_mem_addr  = A0;
    m0_mem_wdata = 32'd0;
    m0_mem_wstrb = 4'd0;
    m1_mem_instr = 1'b0;
    m1_mem_addr  = A1;
    m1_mem_wdata = WD1;
    m1_mem_wstrb = 4'hF;
    drv(1'b0, 1'b0, 1'b0, 32'd0);

    // single m0 read, ready after 3 owned cycles
    vecs[0]  = mk(1, 1, 0, 0, 32'h0,  2'b00, 0, 32'h0, 0, 32'h0,  0, 32'h0);
    vecs[1]  = mk(0, 1, 0, 0, 32'h0,  2'b01, 1, A0,    0, 32'h0,  0, 32'h0);
    vecs[2]  = mk(0, 1, 0, 0, 32'h0,  2'b01, 1, A0,    0, 32'h0,  0, 32'h0);
    vecs[3]  = mk(0, 1, 0, 1, 32'h13, 2'b01, 1, A0,    1, 32'h13, 0, 32'h0);
    vecs[4]  = mk(0, 0, 0, 0, 32'h0,  2'b00, 0, 32'h0, 0, 32'h0,  0, 32'h0);
    // tie from reset, zero-latency memory: alternation, then m1 re-request bubble
    vecs[5]  = mk(1, 1, 1, 1, 32'hA0, 2'b00, 0, 32'h0, 0, 32'h0,  0, 32'h0);
    vecs[6]  = mk(0, 1, 1, 1, 32'hA1, 2'b01, 1, A0,    1, 32'hA1, 0, 32'h0);
    vecs[7]  = mk(0, 1, 1, 1, 32'hA2, 2'b10, 1, A1,    0, 32'h0,  1, 32'hA2);
    vecs[8]  = mk(0, 1, 1, 1, 32'hA3, 2'b01, 1, A0,    1, 32'hA3, 0, 32'h0);
    vecs[9]  = mk(0, 0, 1, 1, 32'hA4, 2'b10, 1, A1,    0, 32'h0,  1, 32'hA4);
    vecs[10] = mk(0, 0, 1, 0, 32'h0,  2'b00, 0, 32'h0, 0, 32'h0,  0, 32'h0);
    vecs[11] = mk(0, 0, 1, 1, 32'hA5, 2'b10, 1, A1,    0, 32'h0,  1, 32'hA5);
    vecs[12] = mk(0, 0, 0, 0, 32'h0,  2'b00, 0, 32'h0, 0, 32'h0,  0, 32'h0);

    #1;
    check("reset_state",
          {grant, mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, m0_mem_ready,
           m1_mem_ready, m0_mem_rdata, m1_mem_rdata, timeout_err, proto_err},
          128'd0);
    cyc_end();
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].rst) do_reset();
      drv(vecs[i].m0v, vecs[i].m1v, vecs[i].rdy, vecs[i].rd);
      #4;
      check($sformatf("vec%0d", i),
            {grant, mem_valid, mem_addr, m0_mem_ready, m0_mem_rdata, m1_mem_ready, m1_mem_rdata},
            {vecs[i].g, vecs[i].mv, vecs[i].ma, vecs[i].r0, vecs[i].d0, vecs[i].r1, vecs[i].d1});
      cyc_end();
    end

    // watchdog: m1 write, memory never ready
    do_reset();
    drv(1'b0, 1'b1, 1'b0, 32'd0);
    #4 check("to_idle_grant", {126'd0, grant}, 128'd0);
    cyc_end();
    for (int k = 1; k <= 4; k++) begin
      #4 check($sformatf("to_wait%0d", k),
               {grant, mem_valid, m1_mem_ready, mem_addr, mem_wdata, mem_wstrb},
               {2'b10, 1'b1, 1'b0, A1, WD1, 4'hF});
      cyc_end();
    end
    #4 check("to_fire", {m1_mem_ready, m1_mem_rdata, mem_valid, m0_mem_ready},
                        {1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0});
    cyc_end();
    drv(1'b0, 1'b0, 1'b0, 32'd0);
    #4 check("to_flags", {timeout_err, proto_err, grant}, {1'b1, 1'b0, 2'b00});
    cyc_end();

    // genuine ready on the timeout cycle wins
    do_reset();
    drv(1'b1, 1'b0, 1'b0, 32'd0);
    cyc_end();
    for (int k = 1; k <= 4; k++) cyc_end();
    drv(1'b1, 1'b0, 1'b1, 32'h1234_5678);
    #4 check("tie_ready", {m0_mem_ready, m0_mem_rdata, mem_valid, mem_instr},
                          {1'b1, 32'h1234_5678, 1'b1, 1'b1});
    cyc_end();
    drv(1'b0, 1'b0, 1'b0, 32'd0);
    #4 check("tie_flags", {timeout_err, grant}, {1'b0, 2'b00});
    cyc_end();

    // owner drops valid before ready
    do_reset();
    drv(1'b1, 1'b0, 1'b0, 32'd0);
    cyc_end();
    #4 check("pe_owned", {grant, mem_valid}, {2'b01, 1'b1});
    cyc_end();
    cyc_end();
    drv(1'b0, 1'b0, 1'b0, 32'd0);
    #4 check("pe_drop", {mem_valid, m0_mem_ready, grant, proto_err}, {1'b0, 1'b0, 2'b01, 1'b0});
    cyc_end();
    #4 check("pe_after", {proto_err, timeout_err, grant}, {1'b1, 1'b0, 2'b00});
    cyc_end();

    // asynchronous reset while m1 owns the bus
    do_reset();
    drv(1'b0, 1'b1, 1'b0, 32'd0);
    cyc_end();
    #4 check("rst_owned", {grant, mem_valid}, {2'b10, 1'b1});
    reset = 1'b1;
    #1 check("rst_async",
             {grant, mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, m0_mem_ready,
              m1_mem_ready, m1_mem_rdata, proto_err, timeout_err},
             128'd0);
    cyc_end();
    reset = 1'b0;
    drv(1'b1, 1'b1, 1'b0, 32'd0);
    #4 check("rst_tie_idle", {126'd0, grant}, 128'd0);
    cyc_end();
    #4 check("rst_tie_m0", {126'd0, grant}, {126'd0, 2'b01});
    cyc_end();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d", total);
    $fatal(1);
  end

endmodule

// File: doc/minrv32_mem_arbiter.md
# minrv32_mem_arbiter

Two-master arbiter sharing the single minrv32 native memory bus (valid/ready, instr, addr, wdata, wstrb, rdata) between the core (master 0) and a secondary requester such as a debug loader or DMA (master 1). Sits between the minrv32 memory port and the memory/formal memory model. Provides round-robin grant with transaction locking, a bus-hang watchdog and protocol-violation flags.

## Interface

- TIMEOUT_CYCLES, 255: cycles a granted transaction may wait for ready before forced error completion; 0 disables the watchdog.
- ERR_RDATA, 32'hDEAD_BEEF: read data returned on a timed-out transaction.

- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- m0_mem_valid / m1_mem_valid  in  1  master request.
- m0_mem_instr / m1_mem_instr  in  1  request is instruction fetch.
- m0_mem_addr / m1_mem_addr  in  32  byte address.
- m0_mem_wdata / m1_mem_wdata  in  32  write data.
- m0_mem_wstrb / m1_mem_wstrb  in  4  byte strobes; 0 = read.
- m0_mem_ready / m1_mem_ready  out  1  completion to master.
- m0_mem_rdata / m1_mem_rdata  out  32  read data to master.
- mem_valid  out  1  request to memory.
- mem_instr  out  1  forwarded instr flag.
- mem_addr  out  32  forwarded address.
- mem_wdata  out  32  forwarded write data.
- mem_wstrb  out  4  forwarded strobes.
- mem_ready  in  1  memory completion.
- mem_rdata  in  32  memory read data.
- grant  out  2  one-hot current owner; 2'b00 when idle.
- timeout_err  out  1  sticky: a watchdog completion occurred.
- proto_err  out  1  sticky: owner dropped valid before ready.

## Operation

- Bus protocol: master holds valid and all request fields stable until ready; ready is a single-cycle pulse; rdata valid in the ready cycle.
- FSM states: IDLE, OWN0, OWN1 (registered). grant = {state==OWN1, state==OWN0}.
- IDLE: if exactly one valid, go to OWN of that master. Both valid: grant the master not served last (last_owner register, reset value 1 so master 0 wins the first tie).
- OWNn: mem_valid/instr/addr/wdata/wstrb = master n's fields (combinational pass-through). mn_mem_ready = mem_ready; mn_mem_rdata = mem_rdata. Other master: ready 0, rdata 0.
- Completion (mem_ready=1 in OWNn): last_owner<=n; if other master valid that cycle, go directly to OWN(other); else IDLE.
- Watchdog: wait counter, width $clog2(TIMEOUT_CYCLES+1), cleared on every entry to OWNn, increments each OWN cycle without mem_ready. When counter==TIMEOUT_CYCLES and mem_ready=0: mn_mem_ready=1, mn_mem_rdata=ERR_RDATA, mem_valid forced 0, timeout_err<=1, next-state as for completion.
- Simultaneous mem_ready and timeout: genuine completion wins, no error flagged, memory rdata returned.
- Owner valid drops before ready: mem_valid follows to 0 that cycle, proto_err<=1, go to IDLE (no ready pulse issued).
- Sticky flags clear only on reset.

## Timing

- Reset values: state IDLE, grant 0, mem_valid 0, mem_instr 0, mem_addr 0, mem_wdata 0, mem_wstrb 0, m*_mem_ready 0, m*_mem_rdata 0, timeout_err 0, proto_err 0, counter 0, last_owner 1.
- IDLE outputs toward memory are all zero.
- Arbitration latency: 1 cycle from valid in IDLE to mem_valid. Back-to-back handover between masters: 0 idle cycles.
- Ready/rdata path from memory to owner: combinational, 0 cycles.
- Same master re-requesting after completion with other idle: passes through IDLE, 1 bubble cycle.
- Reset asserted mid-transaction: immediate return to reset values; no ready pulse to either master.

## Test plan

- m0 read at 0x10000, memory ready after 3 cycles with rdata 0x00000013 -> mem_valid 1 cycle after m0 valid, m0_mem_ready pulse with 0x00000013, m1_mem_ready stays 0, grant 01 then 00.
- m0 and m1 valid same cycle from reset, memory ready immediately each cycle -> m0 served first, m1 granted next cycle without IDLE, then alternation 01,10,01 while both keep requesting.
- m1 write addr 0x20000 wdata 0xCAFEF00D wstrb 4'b1111, memory never ready, TIMEOUT_CYCLES=4 -> m1_mem_ready on 5th owned cycle with rdata 0xDEADBEEF, timeout_err=1, mem_valid 0 that cycle.
- Memory ready on exactly the timeout cycle with rdata 0x12345678 -> master gets 0x12345678, timeout_err stays 0.
- m0 drops valid after 2 owned cycles without ready -> mem_valid 0 same cycle, proto_err=1, state IDLE next cycle.
- reset asserted asynchronously in OWN1 with pending request -> all outputs zero immediately, next tie grants m0.
